sm83_oam_dma_arb: RTL and testbench

//  OAM DMA engine plus CPU/DMA arbiter on the external bus beside the sm83 core.
//  A CPU write to the DMA register copies DMA_LEN bytes from {src_hi,8'h00} into OAM, one byte per M-cycle.

---
 rtl/sm83_oam_dma_arb.sv | 151 +++++++++++++++
 tb/tb_sm83_oam_dma_arb.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sm83_oam_dma_arb.sv
// OAM DMA engine and CPU/DMA arbiter for the external bus next to the sm83 core.
// A write to the DMA register copies one page of DMA_LEN bytes into OAM, one
// byte per M-cycle. CPU accesses below 0xFF00 are locked out while the engine
// owns the bus; the 0xFF00-0xFFFF window (I/O, HRAM, IE) is never arbitrated.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | no transfer; CPU owns the external bus
// ST_PENDING | start delay counting down; bus stays DMA-owned only on restart
// ST_ACTIVE  | one source byte read per M-cycle, written to OAM at its close
module sm83_oam_dma_arb #(
  parameter int                   WORD_SIZE   = 8,
  parameter int                   ADR_WIDTH   = 16,
  parameter int                   DMA_LEN     = 160,
  parameter int                   START_DELAY = 1,
  parameter logic [ADR_WIDTH-1:0] REG_ADR     = 16'hFF46
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mcyc,
  input  logic [ADR_WIDTH-1:0] cpu_adr,
  input  logic [WORD_SIZE-1:0] cpu_dout,
  input  logic                 cpu_rd,
  input  logic                 cpu_wr,
  output logic [WORD_SIZE-1:0] cpu_din,
  input  logic [WORD_SIZE-1:0] hi_din,
  output logic [ADR_WIDTH-1:0] ext_adr,
  output logic [WORD_SIZE-1:0] ext_dout,
  output logic                 ext_rd,
  output logic                 ext_wr,
  input  logic [WORD_SIZE-1:0] ext_din,
  output logic [7:0]           oam_adr,
  output logic [WORD_SIZE-1:0] oam_dout,
  output logic                 oam_wr,
  output logic                 dma_busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_ACTIVE  = 2'd2
  } state_t;

  localparam logic [7:0]           IDX_LAST  = 8'(DMA_LEN - 1);
  localparam logic [7:0]           DLY_LOAD  = 8'(START_DELAY);
  localparam logic [WORD_SIZE-1:0] ECHO_BASE = WORD_SIZE'(8'hE0);
  localparam logic [WORD_SIZE-1:0] ECHO_OFS  = WORD_SIZE'(8'h20);
  localparam logic [WORD_SIZE-1:0] OPEN_BUS  = '1;

  state_t                 state, state_nxt;
  logic [WORD_SIZE-1:0]   src_hi, src_hi_nxt;
  logic [7:0]             idx, idx_nxt;
  logic [7:0]             dly, dly_nxt;
  logic                   blk, blk_nxt;
  logic                   reg_wr;
  logic                   hi_region;
  logic [WORD_SIZE-1:0]   eff_hi;

  assign reg_wr    = mcyc && cpu_wr && (cpu_adr == REG_ADR);
  assign hi_region = (cpu_adr[ADR_WIDTH-1 -: 8] == 8'hFF);
  // Sources in echo RAM and above fold back onto work RAM; no carry out of idx.
  assign eff_hi    = (src_hi >= ECHO_BASE) ? (src_hi - ECHO_OFS) : src_hi;
  assign dma_busy  = (state == ST_ACTIVE) || blk;

  // State and datapath registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      src_hi <= '0;
      idx    <= '0;
      dly    <= '0;
      blk    <= 1'b0;
    end else begin
      state  <= state_nxt;
      src_hi <= src_hi_nxt;
      idx    <= idx_nxt;
      dly    <= dly_nxt;
      blk    <= blk_nxt;
    end
  end

  // Next-state logic; everything advances only on the M-cycle strobe.
  always_comb begin
    state_nxt  = state;
    src_hi_nxt = src_hi;
    idx_nxt    = idx;
    dly_nxt    = dly;
    blk_nxt    = blk;
    if (mcyc) begin
      if (reg_wr) begin
        // A restart from ACTIVE keeps the bus locked through the new delay.
        src_hi_nxt = cpu_dout;
        idx_nxt    = '0;
        dly_nxt    = DLY_LOAD;
        state_nxt  = ST_PENDING;
        blk_nxt    = (state == ST_ACTIVE) || blk;
      end else begin
        case (state)
          ST_PENDING: begin
            dly_nxt = dly - 8'd1;
            if (dly == 8'd1) state_nxt = ST_ACTIVE;
          end
          ST_ACTIVE: begin
            idx_nxt = idx + 8'd1;
            if (idx == IDX_LAST) begin
              state_nxt = ST_IDLE;
              blk_nxt   = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // OAM write happens on the closing clock of each ACTIVE M-cycle.
  always_comb begin
    oam_wr   = !reset && mcyc && (state == ST_ACTIVE);
    oam_adr  = idx;
    oam_dout = ext_din;
  end

  // External bus ownership and CPU read data selection.
  always_comb begin
    ext_adr  = '0;
    ext_dout = '0;
    ext_rd   = 1'b0;
    ext_wr   = 1'b0;
    if (!reset) begin
      if (dma_busy) begin
        ext_adr = {eff_hi, idx};
        ext_rd  = (state == ST_ACTIVE);
      end else begin
        ext_adr  = cpu_adr;
        ext_dout = cpu_dout;
        ext_rd   = cpu_rd && !hi_region;
        ext_wr   = cpu_wr && !hi_region;
      end
    end

    if (cpu_adr == REG_ADR)
      cpu_din = src_hi;
    else if (hi_region)
      cpu_din = hi_din;
    else if (dma_busy)
      cpu_din = OPEN_BUS;
    else
      cpu_din = ext_din;
  end

endmodule

// File: tb/tb_sm83_oam_dma_arb.sv
// Directed bench for sm83_oam_dma_arb: expected OAM writes are queued when the
// DMA register is written and retired by a monitor on every oam_wr pulse.
module tb_sm83_oam_dma_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        mcyc;
  logic [15:0] cpu_adr;
  logic [7:0]  cpu_dout;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [7:0]  cpu_din;
  logic [7:0]  hi_din;
  logic [15:0] ext_adr;
  logic [7:0]  ext_dout;
  logic        ext_rd;
  logic        ext_wr;
  logic [7:0]  ext_din;
  logic [7:0]  oam_adr;
  logic [7:0]  oam_dout;
  logic        oam_wr;
  logic        dma_busy;

  typedef struct {
    logic [7:0]  adr;
    logic [15:0] ext;
    logic [7:0]  data;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  sm83_oam_dma_arb dut (
    .clk      (clk),
    .reset    (reset),
    .mcyc     (mcyc),
    .cpu_adr  (cpu_adr),
    .cpu_dout (cpu_dout),
    .cpu_rd   (cpu_rd),
    .cpu_wr   (cpu_wr),
    .cpu_din  (cpu_din),
    .hi_din   (hi_din),
    .ext_adr  (ext_adr),
    .ext_dout (ext_dout),
    .ext_rd   (ext_rd),
    .ext_wr   (ext_wr),
    .ext_din  (ext_din),
    .oam_adr  (oam_adr),
    .oam_dout (oam_dout),
    .oam_wr   (oam_wr),
    .dma_busy (dma_busy)
  );

  always #5 clk = ~clk;

  // Memory image on the external bus: data depends on the whole address.
  function automatic logic [7:0] mem_val(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
  endfunction

  assign ext_din = mem_val(ext_adr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One M-cycle of four clocks; mcyc is high on the last one.
  task automatic mcycle();
    for (int i = 0; i < 4; i++) begin
      mcyc = (i == 3);
      @(posedge clk);
      #1;
    end
    mcyc = 1'b0;
  endtask

  task automatic run_mcycles(input int n);
    for (int i = 0; i < n; i++) mcycle();
  endtask

  // Writes the DMA register and queues the 160 OAM writes it should cause.
  task automatic reg_write(input logic [7:0] val);
    logic [7:0] eh;
    exp_t       e;
    eh = (val >= 8'hE0) ? val - 8'h20 : val;
    for (int i = 0; i < 160; i++) begin
      e.adr  = i[7:0];
      e.ext  = {eh, i[7:0]};
      e.data = mem_val({eh, i[7:0]});
      sb.push_back(e);
    end
    cpu_adr  = 16'hFF46;
    cpu_dout = val;
    cpu_wr   = 1'b1;
    cpu_rd   = 1'b0;
    mcycle();
    cpu_wr   = 1'b0;
    cpu_adr  = 16'h0000;
    cpu_dout = 8'h00;
  endtask

  // Scoreboard monitor, sampling mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() == 0) begin
      check("idle_oam_wr", {31'd0, oam_wr}, 32'd0);
    end else if (oam_wr) begin
      e = sb.pop_front();
      check("oam_adr", {24'd0, oam_adr}, {24'd0, e.adr});
      check("oam_dout", {24'd0, oam_dout}, {24'd0, e.data});
      check("dma_ext_adr", {16'd0, ext_adr}, {16'd0, e.ext});
      check("dma_ext_rd", {31'd0, ext_rd}, 32'd1);
    end
  end

  initial begin
    reset = 1'b1; mcyc = 1'b0;
    cpu_adr = 16'h1234; cpu_dout = 8'h00; cpu_rd = 1'b1; cpu_wr = 1'b0;
    hi_din = 8'hA5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ext_adr", {16'd0, ext_adr}, 32'd0);
    check("rst_ext_rd", {31'd0, ext_rd}, 32'd0);
    check("rst_busy", {31'd0, dma_busy}, 32'd0);
    check("rst_oam_wr", {31'd0, oam_wr}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Idle pass-through
    @(negedge clk);
    check("pass_adr", {16'd0, ext_adr}, 32'h1234);
    check("pass_rd", {31'd0, ext_rd}, 32'd1);
    check("pass_din", {24'd0, cpu_din}, {24'd0, mem_val(16'h1234)});
    cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_adr = 16'h8000; cpu_dout = 8'h77;
    @(negedge clk);
    check("pass_wr", {31'd0, ext_wr}, 32'd1);
    check("pass_dout", {24'd0, ext_dout}, 32'h77);
    cpu_adr = 16'hFF85; cpu_rd = 1'b1;
    @(negedge clk);
    check("hi_no_wr", {31'd0, ext_wr}, 32'd0);
    check("hi_no_rd", {31'd0, ext_rd}, 32'd0);
    check("hi_din", {24'd0, cpu_din}, 32'hA5);
    cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_adr = 16'h0000; cpu_dout = 8'h00;

    // Test 1/2: transfer from C100
    reg_write(8'hC1);
    check("t1_pend_busy", {31'd0, dma_busy}, 32'd0);
    cpu_adr = 16'h2222; cpu_rd = 1'b1;
    @(negedge clk);
    check("t1_pend_pass", {16'd0, ext_adr}, 32'h2222);
    cpu_adr = 16'h0000; cpu_rd = 1'b0;
    mcycle();
    check("t1_act_busy", {31'd0, dma_busy}, 32'd1);
    check("t1_first_adr", {16'd0, ext_adr}, 32'hC100);
    run_mcycles(10);
    cpu_adr = 16'hC000; cpu_rd = 1'b1;
    @(negedge clk);
    check("t2_blk_din", {24'd0, cpu_din}, 32'hFF);
    check("t2_blk_adr", {16'd0, ext_adr}, 32'hC10A);
    cpu_adr = 16'hFF85; hi_din = 8'h5E;
    @(negedge clk);
    check("t2_hi_din", {24'd0, cpu_din}, 32'h5E);
    check("t2_hi_adr", {16'd0, ext_adr}, 32'hC10A);
    cpu_adr = 16'h8000; cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_dout = 8'h99;
    @(negedge clk);
    check("t2_wr_drop", {31'd0, ext_wr}, 32'd0);
    cpu_adr = 16'hFF46; cpu_wr = 1'b0; cpu_rd = 1'b1;
    @(negedge clk);
    check("t2_reg_rd", {24'd0, cpu_din}, 32'hC1);
    cpu_adr = 16'h0000; cpu_rd = 1'b0; cpu_dout = 8'h00;
    run_mcycles(149);
    check("t1_last_busy", {31'd0, dma_busy}, 32'd1);
    mcycle();
    check("t1_done_busy", {31'd0, dma_busy}, 32'd0);
    check("t1_sb_empty", sb.size(), 32'd0);

    // Test 3: restart at idx 50
    reg_write(8'h40);
    mcycle();
    run_mcycles(50);
    while (sb.size() > 1) void'(sb.pop_back());
    reg_write(8'hD0);
    check("t3_pend_busy", {31'd0, dma_busy}, 32'd1);
    cpu_adr = 16'hC000; cpu_rd = 1'b1;
    @(negedge clk);
    check("t3_pend_blk_din", {24'd0, cpu_din}, 32'hFF);
    cpu_adr = 16'h0000; cpu_rd = 1'b0;
    mcycle();
    check("t3_act_adr", {16'd0, ext_adr}, 32'hD000);
    check("t3_act_busy", {31'd0, dma_busy}, 32'd1);
    run_mcycles(160);
    check("t3_done_busy", {31'd0, dma_busy}, 32'd0);
    check("t3_sb_empty", sb.size(), 32'd0);

    // Test 4: echo source FE -> DE00
    reg_write(8'hFE);
    mcycle();
    check("t4_first_adr", {16'd0, ext_adr}, 32'hDE00);
    cpu_adr = 16'hFF46; cpu_rd = 1'b1;
    @(negedge clk);
    check("t4_reg_rd", {24'd0, cpu_din}, 32'hFE);
    cpu_adr = 16'h0000; cpu_rd = 1'b0;
    run_mcycles(160);
    check("t4_done_busy", {31'd0, dma_busy}, 32'd0);
    check("t4_sb_empty", sb.size(), 32'd0);

    // Test 5: reset at idx 20
    reg_write(8'h33);
    mcycle();
    run_mcycles(20);
    check("t5_busy_before", {31'd0, dma_busy}, 32'd1);
    reset = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    cpu_adr = 16'h4567; cpu_rd = 1'b1;
    #1;
    check("t5_busy", {31'd0, dma_busy}, 32'd0);
    check("t5_adr", {16'd0, ext_adr}, 32'h4567);
    check("t5_rd", {31'd0, ext_rd}, 32'd1);
    cpu_adr = 16'h0000; cpu_rd = 1'b0;
    run_mcycles(10);
    check("t5_still_idle", {31'd0, dma_busy}, 32'd0);

    // Test 6: register write on the final ACTIVE mcyc
    reg_write(8'h55);
    mcycle();
    run_mcycles(159);
    check("t6_one_left", sb.size(), 32'd1);
    reg_write(8'h80);
    check("t6_busy", {31'd0, dma_busy}, 32'd1);
    check("t6_sb_len", sb.size(), 32'd160);
    mcycle();
    check("t6_first_adr", {16'd0, ext_adr}, 32'h8000);
    run_mcycles(160);
    check("t6_done_busy", {31'd0, dma_busy}, 32'd0);
    check("t6_sb_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
